seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised multi-cycle magnitude comparator for WIDTH-bit operands.
- Scans CHUNK bits per clock, MSB-first, and stops early at the first differing chunk.
- Supports unsigned and two's-complement compare, selected per operation.
- Uses a start/busy/done handshake and registered gt/lt/eq flags; it is the shared compare unit for wider datapaths.

Parameters:
- WIDTH, 16, operand width in bits; must be ≥ CHUNK.
- CHUNK, 4, bits compared per cycle; WIDTH must be an integer multiple of CHUNK.
- NCHUNK (localparam), WIDTH/CHUNK, number of chunks.
- CW (localparam), $clog2(NCHUNK+1), width of cycle counter output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; accepted only when busy=0.
- a_in  in  WIDTH  operand A; sampled on the accepting edge only.
- b_in  in  WIDTH  operand B; sampled on the accepting edge only.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- busy  out  1  high from the edge after acceptance until the return to IDLE.
- done  out  1  one-cycle pulse; flags are valid and updated in this cycle.
- a_gt  out  1  registered A > B.
- a_lt  out  1  registered A < B.
- a_eq  out  1  registered A == B.
- cycles  out  CW  number of chunks examined by the last compare (1..NCHUNK).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, a_gt, a_lt, a_eq = 0; cycles = 0; operand registers cleared. Reset mid-compare aborts the compare; no done is produced.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge loads sa<=a_in and sb<=b_in, with the MSB of both inverted when signed_mode=1 (offset-binary mapping, so unsigned compare gives the signed order).
  - The same edge clears the chunk counter and moves to CMP.
  - Flags are not changed by acceptance.
- CMP, each edge:
  - Compare the top CHUNK bits of sa and sb; increment the chunk counter.
  - Top chunks differ: register a_gt/a_lt from that chunk compare, a_eq=0, cycles=counter+1, done=1, go to DONE.
  - Equal and this is chunk NCHUNK: a_eq=1, a_gt=a_lt=0, cycles=NCHUNK, done=1, go to DONE.
  - Equal otherwise: shift sa and sb left by CHUNK (zero fill) and stay in CMP.
- DONE:
  - done=1 for exactly this cycle; busy=1.
  - Next edge: done<=0 and go to IDLE.
  - start is ignored in DONE and in CMP; there is no queuing.
- Latency: start accepted at edge 0 gives done high in the cycle after edge k, where k = chunks examined. Minimum k = 1 (first chunk differs); maximum k = NCHUNK (equal operands, or difference only in the last chunk). Next acceptance is possible at edge k+2.
- Output hold: a_gt, a_lt, a_eq and cycles hold their values until the next done. Exactly one flag is high after any completed compare. All flags are 0 only after reset, before the first completion.
- Operand inputs and signed_mode may change freely while busy=1 without effect.
- start held high continuously: a new compare is accepted at every IDLE edge, i.e. back-to-back with one IDLE cycle between operations.

Test Plan:
All cases use WIDTH=16, CHUNK=4.
- Equal operands: a=0x1234, b=0x1234, unsigned → done 4 cycles after accept; a_eq=1, a_gt=a_lt=0, cycles=4.
- Early exit on MSB:
  - a=0x8000, b=0x7FFF, signed_mode=0 → a_gt=1, cycles=1, done 1 cycle after accept.
  - Same operands with signed_mode=1 → a_lt=1, cycles=1.
- Mid-word difference: a=0x12F0, b=0x12E0, unsigned → a_gt=1, cycles=3.
- Signed negatives: a=0xFFFF (−1), b=0xFFFE (−2), signed_mode=1 → a_gt=1, cycles=4.
- start pulsed during CMP with different operands → ignored: busy remains 1, result matches the original operands, and a single done pulse is produced.
- rst_n driven low for one cycle during CMP of 0x1234 vs 0x1235 → flags, cycles, busy and done all 0 immediately (asynchronous); no done pulse follows; a new start after reset completes normally.

Source files
------------

// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand bundle for seq_mag_comparator.
// master: requester side (drives start, operands, signed_mode; observes status and flags).
// slave : comparator side (samples request, drives busy/done/gt/lt/eq/cycles).
interface seq_mag_comparator_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) ();
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK + 1);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             a_gt;
    logic             a_lt;
    logic             a_eq;
    logic [CW-1:0]    cycles;

    modport master (
        output start, a_in, b_in, signed_mode,
        input  busy, done, a_gt, a_lt, a_eq, cycles
    );

    modport slave (
        input  start, a_in, b_in, signed_mode,
        output busy, done, a_gt, a_lt, a_eq, cycles
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per clock MSB-first and
// stops at the first differing chunk. Signed compares map both operands to
// offset binary on load so a single unsigned chunk compare serves both modes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_mag_comparator_if (start/a_in/b_in/signed_mode in;
//           busy/done/a_gt/a_lt/a_eq/cycles out, all registered)
module seq_mag_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_mag_comparator_if.slave  bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK + 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cycles_q, cycles_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic [CHUNK-1:0] top_a;
    logic [CHUNK-1:0] top_b;
    logic [WIDTH-1:0] flip_mask;

    // Chunk currently under compare always sits at the top of the shifters.
    assign top_a     = sa_q[WIDTH-1 -: CHUNK];
    assign top_b     = sb_q[WIDTH-1 -: CHUNK];
    // Inverting the sign bit turns two's complement order into unsigned order.
    assign flip_mask = bus.signed_mode ? MSB_MASK : '0;

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a_in ^ flip_mask;
                    sb_d    = bus.b_in ^ flip_mask;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_q + CW'(1);
                if (top_a != top_b) begin
                    gt_d     = (top_a > top_b);
                    lt_d     = (top_a < top_b);
                    eq_d     = 1'b0;
                    cycles_d = cnt_q + CW'(1);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CW'(NCHUNK - 1)) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b1;
                    cycles_d = CW'(NCHUNK);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    sa_d = sa_q << CHUNK;
                    sb_d = sb_q << CHUNK;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_gt   = gt_q;
    assign bus.a_lt   = lt_q;
    assign bus.a_eq   = eq_q;
    assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (WIDTH=16, CHUNK=4): directed
// cases plus randomized operands checked against an arithmetic reference model.
module tb_seq_mag_comparator;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned MAXLAT = 40;

    logic clk = 1'b0;
    logic rst_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seq_mag_comparator_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    seq_mag_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer compare; chunks examined follow from the
    // highest differing bit (the signed remap never changes which bits differ).
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sm,
                         output int unsigned gt, output int unsigned lt,
                         output int unsigned eq, output int unsigned k);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        x;
        bit                      found;
        sa = a;
        sb = b;
        if (sm) begin
            gt = (sa > sb) ? 1 : 0;
            lt = (sa < sb) ? 1 : 0;
        end else begin
            gt = (a > b) ? 1 : 0;
            lt = (a < b) ? 1 : 0;
        end
        eq    = (a == b) ? 1 : 0;
        x     = a ^ b;
        k     = NCHUNK;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                k     = NCHUNK - (i / CHUNK);
                found = 1'b1;
            end
        end
    endtask

    // One full compare. Called at a negedge with busy=0; returns at the negedge
    // after done has dropped. Optionally pulses start mid-compare.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic sm,
                          input bit poke_start);
        int unsigned gt, lt, eq, k, lat;
        model(a, b, sm, gt, lt, eq, k);
        bus.start       = 1'b1;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.signed_mode = sm;
        @(negedge clk);
        check_eq({tag, ".busy_after_accept"}, 32'(bus.busy), 1);
        bus.start       = 1'b0;
        bus.a_in        = 16'($urandom);
        bus.b_in        = 16'($urandom);
        bus.signed_mode = 1'($urandom);
        lat = 0;
        while (!bus.done && lat < MAXLAT) begin
            if (poke_start && lat == 1) begin
                bus.start = 1'b1;
                bus.a_in  = ~a;
                bus.b_in  = b ^ 16'h5a5a;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (!bus.done)
                check_eq({tag, ".busy_in_cmp"}, 32'(bus.busy), 1);
        end
        bus.start = 1'b0;
        check_eq({tag, ".latency"}, lat, k);
        check_eq({tag, ".gt"}, 32'(bus.a_gt), gt);
        check_eq({tag, ".lt"}, 32'(bus.a_lt), lt);
        check_eq({tag, ".eq"}, 32'(bus.a_eq), eq);
        check_eq({tag, ".cycles"}, 32'(bus.cycles), k);
        check_eq({tag, ".busy_at_done"}, 32'(bus.busy), 1);
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 32'(bus.done), 0);
        check_eq({tag, ".busy_idle"}, 32'(bus.busy), 0);
        check_eq({tag, ".hold_cycles"}, 32'(bus.cycles), k);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int unsigned      dones;

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        bus.signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset.busy", 32'(bus.busy), 0);
        check_eq("reset.done", 32'(bus.done), 0);
        check_eq("reset.flags", 32'({bus.a_gt, bus.a_lt, bus.a_eq}), 0);
        check_eq("reset.cycles", 32'(bus.cycles), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op("equal",      16'h1234, 16'h1234, 1'b0, 1'b0);
        run_op("msb_uns",    16'h8000, 16'h7FFF, 1'b0, 1'b0);
        run_op("msb_sgn",    16'h8000, 16'h7FFF, 1'b1, 1'b0);
        run_op("mid",        16'h12F0, 16'h12E0, 1'b0, 1'b0);
        run_op("neg",        16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
        run_op("last_chunk", 16'hABC0, 16'hABC1, 1'b0, 1'b0);
        run_op("poke",       16'h4321, 16'h4321, 1'b0, 1'b1);

        // A start pulsed mid-compare must not spawn a second operation.
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_eq("poke.no_extra_done", dones, 0);
        check_eq("poke.idle_busy", 32'(bus.busy), 0);

        // Asynchronous reset during CMP.
        bus.start = 1'b1;
        bus.a_in  = 16'h1234;
        bus.b_in  = 16'h1235;
        bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid.busy", 32'(bus.busy), 0);
        check_eq("rst_mid.done", 32'(bus.done), 0);
        check_eq("rst_mid.flags", 32'({bus.a_gt, bus.a_lt, bus.a_eq}), 0);
        check_eq("rst_mid.cycles", 32'(bus.cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_eq("rst_mid.no_done", dones, 0);
        run_op("after_rst", 16'h1234, 16'h1235, 1'b0, 1'b0);

        // start held high: back-to-back compares with one IDLE cycle between.
        bus.start       = 1'b1;
        bus.a_in        = 16'h8000;
        bus.b_in        = 16'h7FFF;
        bus.signed_mode = 1'b0;
        @(negedge clk);
        check_eq("b2b.e0_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check_eq("b2b.e1_done", 32'(bus.done), 1);
        check_eq("b2b.e1_gt", 32'(bus.a_gt), 1);
        bus.signed_mode = 1'b1;
        @(negedge clk);
        check_eq("b2b.e2_busy", 32'(bus.busy), 0);
        check_eq("b2b.e2_done", 32'(bus.done), 0);
        @(negedge clk);
        check_eq("b2b.e3_busy", 32'(bus.busy), 1);
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("b2b.e4_done", 32'(bus.done), 1);
        check_eq("b2b.e4_lt", 32'(bus.a_lt), 1);
        @(negedge clk);
        @(negedge clk);

        // Randomized compares, biased toward equal prefixes to spread latency.
        for (int n = 0; n < 60; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                default: begin
                    rb = ra ^ (16'($urandom_range(1, 15)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
                end
            endcase
            run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
